// File: rtl/serial_alu_pkg.sv
// Shared types and defaults for the bit-serial ALU datapath.
package serial_alu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/full_adder.sv
// Single 1-bit full-adder cell; the additive mirror of the 1-bit subtract cell.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial two's-complement adder: one full-adder cell, LSB first, one bit per clock,
// with valid/ready handshakes on both the operand and result sides.
module serial_adder
    import serial_alu_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);

    localparam int               CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]    LAST_BIT = CW'(WIDTH - 1);

    state_e           state_q,   state_d;
    logic [WIDTH-1:0] shift_a_q, shift_a_d;
    logic [WIDTH-1:0] shift_b_q, shift_b_d;
    logic [WIDTH-1:0] sum_sr_q,  sum_sr_d;
    logic [CW-1:0]    cnt_q,     cnt_d;
    logic             carry_q,   carry_d;
    logic             cmsb_q,    cmsb_d;
    logic [WIDTH-1:0] sum_q,     sum_d;
    logic             cout_q,    cout_d;

    logic             fa_s;
    logic             fa_cout;

    full_adder u_fa (
        .a    (shift_a_q[0]),
        .b    (shift_b_q[0]),
        .cin  (carry_q),
        .s    (fa_s),
        .cout (fa_cout)
    );

    // Next-state and datapath update for the IDLE/RUN/DONE sequencer.
    always_comb begin
        state_d   = state_q;
        shift_a_d = shift_a_q;
        shift_b_d = shift_b_q;
        sum_sr_d  = sum_sr_q;
        cnt_d     = cnt_q;
        carry_d   = carry_q;
        cmsb_d    = cmsb_q;
        sum_d     = sum_q;
        cout_d    = cout_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_d   = RUN;
                    shift_a_d = a;
                    shift_b_d = b;
                    sum_sr_d  = '0;
                    cnt_d     = '0;
                    carry_d   = 1'b0;
                end else begin
                    state_d   = IDLE;
                end
            end
            RUN: begin
                sum_sr_d  = {fa_s, sum_sr_q[WIDTH-1:1]};
                carry_d   = fa_cout;
                shift_a_d = shift_a_q >> 1;
                shift_b_d = shift_b_q >> 1;
                // Last bit: the carry still in the flop is the carry into the MSB.
                if (cnt_q == LAST_BIT) begin
                    state_d = DONE;
                    cnt_d   = '0;
                    cmsb_d  = carry_q;
                    sum_d   = {fa_s, sum_sr_q[WIDTH-1:1]};
                    cout_d  = fa_cout;
                end else begin
                    state_d = RUN;
                    cnt_d   = cnt_q + CW'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            shift_a_q <= '0;
            shift_b_q <= '0;
            sum_sr_q  <= '0;
            cnt_q     <= '0;
            carry_q   <= 1'b0;
            cmsb_q    <= 1'b0;
            sum_q     <= '0;
            cout_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_a_q <= shift_a_d;
            shift_b_q <= shift_b_d;
            sum_sr_q  <= sum_sr_d;
            cnt_q     <= cnt_d;
            carry_q   <= carry_d;
            cmsb_q    <= cmsb_d;
            sum_q     <= sum_d;
            cout_q    <= cout_d;
        end
    end

    // Handshake flags are pure state decodes; in_ready is also held low during reset.
    assign in_ready  = (state_q == IDLE) && !rst;
    assign out_valid = (state_q == DONE);
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign overflow  = cmsb_q ^ cout_q;

endmodule

// File: doc/serial_adder.md
# serial_adder

Bit-serial two's-complement adder, the additive counterpart of the team's 1-bit subtract cell in the 1-bit ALU datapath. It accepts two WIDTH-bit operands over a valid/ready handshake and processes them LSB-first, one bit per clock, through a single 1-bit full-adder cell with a registered carry. It then presents the sum, carry-out and signed overflow over a second valid/ready handshake. Area-minimal arithmetic for the ALU's multi-bit ops, trading latency for a single adder cell.

## Interface
- WIDTH, 8, operand and sum width in bits (legal range 2–32).

- clk  in  1  sole clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operands a/b valid.
- in_ready  out  1  block can accept operands.
- a  in  WIDTH  addend A, sampled on the input handshake.
- b  in  WIDTH  addend B, sampled on the input handshake.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- sum  out  WIDTH  (a + b) mod 2^WIDTH.
- cout  out  1  unsigned carry-out of bit WIDTH-1.
- overflow  out  1  signed overflow: carry into MSB XOR carry out of MSB.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready: load a→shift_a and b→shift_b.
  - Clear the carry flop, bit counter and sum shift register.
  - Go to RUN.
- RUN, one cycle per bit:
  - The full-adder cell takes shift_a[0], shift_b[0] and carry.
  - Its sum bit shifts into sum_sr from the MSB end (sum_sr <= {s, sum_sr[WIDTH-1:1]}).
  - Its carry result is written to the carry flop.
  - shift_a and shift_b shift right by one.
  - The counter increments.
- Carry capture:
  - On the cycle the counter equals WIDTH-1, the old carry value is captured as carry-into-MSB.
  - After that cycle, go to DONE.
- DONE:
  - out_valid=1.
  - sum, cout and overflow are stable and held while out_ready=0.
  - On out_valid&out_ready, go to IDLE.
- in_ready=0 in RUN and DONE: no overlap of operations, and in_valid is ignored there.
- Arithmetic is modular. The carry flop is 1 bit. The counter is $clog2(WIDTH) bits wide and must not wrap before WIDTH-1.
- a/b may change freely after acceptance; only the values sampled on the handshake edge matter.
- sum/cout/overflow hold the last result in IDLE. They are cleared only by rst or overwritten at the next DONE entry.

## Timing
- Reset values:
  - State IDLE.
  - out_valid=0, sum=0, cout=0, overflow=0, counter=0, carry=0.
  - in_ready=0 while rst is high; in_ready=1 in the first cycle after rst deasserts.
- Latency:
  - Operands are accepted at edge k.
  - out_valid is first high in the cycle after edge k+WIDTH, i.e. WIDTH cycles after acceptance.
- Throughput:
  - With out_ready held high and in_valid held high, one result every WIDTH+2 cycles: accept, WIDTH bit cycles, DONE (1 cycle), IDLE (1 cycle).
- in_ready and out_valid are decoded directly from state registers, with no combinational path from in_valid or out_ready.
- rst mid-operation (RUN or DONE):
  - The next state is IDLE and the partial result is discarded.
  - out_valid is low in the cycle after the reset edge.
  - No output handshake is issued for the aborted operation.
- in_valid and out_ready are sampled only in IDLE and DONE respectively. Since in_ready=0 in DONE, simultaneous input and output handshakes are impossible.

## Structure
- Shared package serial_alu_pkg:
  - State enum {IDLE, RUN, DONE} (2-bit encoding).
  - Default WIDTH constant.
- Sub-module full_adder (a, b, cin → s, cout). This is the single combinational cell, the mirror of the existing 1-bit subtract cell.
- The top level holds the FSM, counter, operand and sum shift registers, carry flop and MSB-carry capture flop.

## Test plan
- WIDTH=8, a=0x5A, b=0x33 → out_valid after 8 cycles, sum=0x8D, cout=0, overflow=1.
- a=0xFF, b=0x01 → sum=0x00, cout=1, overflow=0; a=0x80, b=0x80 → sum=0x00, cout=1, overflow=1.
- Backpressure: a=0x10, b=0x20, out_ready low for 5 cycles in DONE → sum=0x30 held constant, in_ready=0 throughout, then completes on out_ready.
- Reset mid-RUN after 3 bit cycles → out_valid=0 and in_ready=1 in the first cycle after rst deasserts; next operation 0x01+0x01 → sum=0x02, unaffected by prior carry.
- Back-to-back: in_valid and out_ready held high with 4 operand pairs → results in order, spaced exactly 10 cycles apart (WIDTH+2).
- Random: 1000 random pairs with random out_ready stalls → sum/cout/overflow match a reference model, exactly one output handshake per input handshake.
